spike_isi_meter: RTL and testbench



---
 rtl/spike_isi_meter.sv | 140 ++++++++++++++
 tb/tb_spike_isi_meter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_isi_meter.sv
// spike_isi_meter: rising-edge spike detector that measures the inter-spike
// interval in clock cycles and counts spikes per fixed window (firing rate).
// All outputs are registered. Reset is synchronous and active-low.
module spike_isi_meter #(
  parameter int ISI_W      = 16,
  parameter int CNT_W      = 8,
  parameter int WIN_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spike,
  input  logic             clear,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid,
  output logic             isi_sat,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  output logic             timing
);

  localparam int WIN_W = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    SAT    = 2'd2
  } state_t;

  state_t           state_reg;
  logic             spike_d_reg;
  logic [ISI_W-1:0] cnt_reg;
  logic [WIN_W-1:0] win_cnt_reg;
  logic [CNT_W-1:0] spk_cnt_reg;

  logic             spike_edge;
  logic             win_close;
  logic [ISI_W-1:0] cnt_inc;
  logic [CNT_W-1:0] spk_inc;
  logic [CNT_W-1:0] spk_next;

  assign spike_edge = spike & ~spike_d_reg;
  assign win_close  = (win_cnt_reg == WIN_LAST);
  assign cnt_inc    = cnt_reg + ISI_W'(1);
  // Saturating increment so a burst cannot wrap the window count.
  assign spk_inc    = (spk_cnt_reg == CNT_MAX) ? CNT_MAX : spk_cnt_reg + CNT_W'(1);
  assign spk_next   = spike_edge ? spk_inc : spk_cnt_reg;

  // Delayed spike level for edge detection; keeps tracking during clear so a
  // spike held across clear does not produce a spurious edge afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spike_d_reg <= 1'b0;
    end else begin
      spike_d_reg <= spike;
    end
  end

  // ISI state machine: arms on the first edge, then reports cycles between edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      isi       <= '0;
      isi_valid <= 1'b0;
      isi_sat   <= 1'b0;
      timing    <= 1'b0;
    end else if (clear) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      isi_valid <= 1'b0;
      timing    <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (spike_edge) begin
            cnt_reg   <= ISI_W'(1);
            state_reg <= TIMING;
            timing    <= 1'b1;
          end
        end
        TIMING: begin
          if (spike_edge) begin
            isi       <= cnt_reg;
            isi_sat   <= 1'b0;
            isi_valid <= 1'b1;
            cnt_reg   <= ISI_W'(1);
          end else begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == ISI_MAX) begin
              state_reg <= SAT;
            end
          end
        end
        SAT: begin
          // Counter parks at all-ones until the next edge closes the interval.
          if (spike_edge) begin
            isi       <= ISI_MAX;
            isi_sat   <= 1'b1;
            isi_valid <= 1'b1;
            cnt_reg   <= ISI_W'(1);
            state_reg <= TIMING;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          timing    <= 1'b0;
        end
      endcase
    end
  end

  // Free-running window; an edge on the closing cycle belongs to the closing window.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      win_cnt_reg <= '0;
      spk_cnt_reg <= '0;
      rate        <= '0;
      rate_valid  <= 1'b0;
    end else if (clear) begin
      win_cnt_reg <= '0;
      spk_cnt_reg <= '0;
      rate_valid  <= 1'b0;
    end else if (win_close) begin
      win_cnt_reg <= '0;
      spk_cnt_reg <= '0;
      rate        <= spk_next;
      rate_valid  <= 1'b1;
    end else begin
      win_cnt_reg <= win_cnt_reg + WIN_W'(1);
      spk_cnt_reg <= spk_next;
      rate_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_isi_meter.sv
// Testbench for spike_isi_meter: directed scenarios followed by random spikes,
// every cycle compared against a timestamp-based reference model.
module tb_spike_isi_meter;

  localparam int ISI_W = 6;
  localparam int CNT_W = 3;
  localparam int WIN   = 24;
  localparam int IMAX  = (1 << ISI_W) - 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset_n;
  logic             spike;
  logic             clear;
  logic [ISI_W-1:0] isi;
  logic             isi_valid;
  logic             isi_sat;
  logic [CNT_W-1:0] rate;
  logic             rate_valid;
  logic             timing;

  int n_asserts;
  int n_fail;

  // Reference model state: time stamps and plain counts.
  int   cyc;
  logic m_prev;
  bit   m_armed;
  int   m_last;
  int   m_win_start;
  int   m_wcount;
  int   e_isi, e_rate;
  bit   e_isi_valid, e_isi_sat, e_rate_valid, e_timing;

  spike_isi_meter #(.ISI_W(ISI_W), .CNT_W(CNT_W), .WIN_CYCLES(WIN)) dut (
    .clk(clk), .reset_n(reset_n), .spike(spike), .clear(clear),
    .isi(isi), .isi_valid(isi_valid), .isi_sat(isi_sat),
    .rate(rate), .rate_valid(rate_valid), .timing(timing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_update(input logic sp, input logic cl, input logic rn);
    bit e;
    int d;
    if (!rn) begin
      m_prev = 1'b0; m_armed = 0; m_wcount = 0; m_win_start = cyc + 1;
      e_isi = 0; e_isi_valid = 0; e_isi_sat = 0;
      e_rate = 0; e_rate_valid = 0;
    end else begin
      e = sp && !m_prev;
      m_prev = sp;
      e_isi_valid = 0;
      e_rate_valid = 0;
      if (cl) begin
        m_armed = 0; m_wcount = 0; m_win_start = cyc + 1;
      end else begin
        if (e) begin
          if (m_armed) begin
            d = cyc - m_last;
            e_isi = (d >= IMAX) ? IMAX : d;
            e_isi_sat = (d >= IMAX);
            e_isi_valid = 1;
          end
          m_armed = 1;
          m_last = cyc;
        end
        if (cyc - m_win_start == WIN - 1) begin
          e_rate = (m_wcount + int'(e) > CMAX) ? CMAX : m_wcount + int'(e);
          e_rate_valid = 1;
          m_wcount = 0;
          m_win_start = cyc + 1;
        end else begin
          m_wcount = m_wcount + int'(e);
        end
      end
    end
    e_timing = m_armed;
  endtask

  task automatic step(input logic sp, input logic cl, input logic rn);
    @(negedge clk);
    spike = sp; clear = cl; reset_n = rn;
    @(posedge clk);
    model_update(sp, cl, rn);
    #1;
    chk("isi", 32'(isi), 32'(e_isi));
    chk("isi_valid", 32'(isi_valid), 32'(e_isi_valid));
    chk("isi_sat", 32'(isi_sat), 32'(e_isi_sat));
    chk("rate", 32'(rate), 32'(e_rate));
    chk("rate_valid", 32'(rate_valid), 32'(e_rate_valid));
    chk("timing", 32'(timing), 32'(e_timing));
    $display("cyc=%0d spike=%0b clear=%0b rst_n=%0b | isi=%0d v=%0b sat=%0b rate=%0d rv=%0b timing=%0b",
             cyc, sp, cl, rn, isi, isi_valid, isi_sat, rate, rate_valid, timing);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int dens;
    logic sp, cl, rn;
    n_asserts = 0; n_fail = 0; cyc = 0;
    m_prev = 0; m_armed = 0; m_last = 0; m_win_start = 0; m_wcount = 0;
    e_isi = 0; e_rate = 0; e_isi_valid = 0; e_isi_sat = 0; e_rate_valid = 0; e_timing = 0;
    spike = 1'b0; clear = 1'b0; reset_n = 1'b0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("rst_isi", 32'(isi), 0);
    chk("rst_rate", 32'(rate), 0);
    chk("rst_timing", 32'(timing), 0);

    // Window saturation: edges at every odd position including the closing one.
    for (int i = 0; i < WIN; i++) step(logic'(i % 2), 1'b0, 1'b1);
    chk("win_sat_rate", 32'(rate), CMAX);
    chk("win_sat_rv", 32'(rate_valid), 1);
    // Next window: two edges.
    for (int i = 0; i < WIN; i++) step(logic'(i == 5 || i == 10), 1'b0, 1'b1);
    chk("win2_rate", 32'(rate), 2);
    chk("win2_rv", 32'(rate_valid), 1);
    // Edge only on the closing cycle, then held high across the boundary.
    for (int i = 0; i < WIN; i++) step(logic'(i == WIN - 1), 1'b0, 1'b1);
    chk("win_close_edge", 32'(rate), 1);
    for (int i = 0; i < WIN; i++) step(1'b1, 1'b0, 1'b1);
    chk("win_held_rate", 32'(rate), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("rv_one_cycle", 32'(rate_valid), 0);

    // Basic ISI: pulses 25 cycles apart.
    step(1'b0, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b1);
    chk("first_edge_no_valid", 32'(isi_valid), 0);
    chk("first_edge_timing", 32'(timing), 1);
    idle(24);
    step(1'b1, 1'b0, 1'b1);
    chk("isi25", 32'(isi), 25);
    chk("isi25_valid", 32'(isi_valid), 1);
    chk("isi25_sat", 32'(isi_sat), 0);
    step(1'b0, 1'b0, 1'b1);
    chk("isi_valid_one_cycle", 32'(isi_valid), 0);

    // Held-high spike gives one edge.
    idle(4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    idle(25);
    step(1'b1, 1'b0, 1'b1);
    chk("isi30_held", 32'(isi), 30);

    // Saturation then recovery.
    idle(70);
    step(1'b1, 1'b0, 1'b1);
    chk("isi_sat_val", 32'(isi), IMAX);
    chk("isi_sat_flag", 32'(isi_sat), 1);
    idle(4);
    step(1'b1, 1'b0, 1'b1);
    chk("isi5_after_sat", 32'(isi), 5);
    chk("isi5_sat_clr", 32'(isi_sat), 0);

    // Clear mid-interval.
    idle(6);
    step(1'b1, 1'b0, 1'b1);
    chk("isi7", 32'(isi), 7);
    idle(3);
    step(1'b0, 1'b1, 1'b1);
    chk("clear_isi_hold", 32'(isi), 7);
    chk("clear_timing", 32'(timing), 0);
    idle(3);
    step(1'b1, 1'b0, 1'b1);
    chk("rearm_no_valid", 32'(isi_valid), 0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("clear_edge_discard", 32'(timing), 0);
    step(1'b0, 1'b0, 1'b1);

    // Reset mid-window with three counted edges.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(logic'(i % 2 == 0), 1'b0, 1'b1);
    idle(4);
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_rate", 32'(rate), 0);
    chk("midrst_timing", 32'(timing), 0);
    for (int i = 0; i < WIN; i++) step(logic'(i == 2 || i == 7), 1'b0, 1'b1);
    chk("post_rst_rate", 32'(rate), 2);

    // Random traffic with varying spike density, occasional clear/reset.
    for (int i = 0; i < 3000; i++) begin
      case ((i / 500) % 6)
        0: dens = 1;
        1: dens = 3;
        2: dens = 8;
        3: dens = 40;
        4: dens = 90;
        default: dens = 2;
      endcase
      sp = ($urandom_range(0, dens) == 0);
      cl = ($urandom_range(0, 199) == 0);
      rn = !($urandom_range(0, 499) == 0);
      step(sp, cl, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
